fractal_view_ctrl: RTL and testbench
====================================

// Module: fractal_view_ctrl
// PURPOSE
//  Sequences frame renders of the fractal engine and owns its view configuration
//  (startX/startY/stepX/stepY). Accepts pan/zoom/home commands, updates the view
//  window about its centre, then restarts the engine through its reset input and
//  waits for its 'display' (frame done) flag. Sits between the user-input logic
//  and the fractal datapath in the top level.
// PARAMETERS
//  START_X0   16'shE000  reset/home startX, signed Q2.13 (-1.0)
//  START_Y0   16'shE000  reset/home startY, signed Q2.13
//  STEP_X0    16'd25     reset/home stepX, unsigned Q2.13 per pixel
//  STEP_Y0    16'd34     reset/home stepY
//  HALF_W     320        half frame width in pixels (zoom pivot)
//  HALF_H     240        half frame height in pixels
//  PAN_SHIFT  5          pan distance = step << PAN_SHIFT (32 pixels)
//  STEP_MIN   16'd1      zoom-in floor, applied to both steps
//  STEP_MAX   16'd2048   zoom-out ceiling, applied to both steps
//  RST_CYC    4          cycles frac_reset is held high per launch (>=1)
//  WAIT_MAX   24'hFFFFFF timeout cycles in WAIT
// PORTS
//  Clk_100M     in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  cmd_valid    in   1   command present
//  cmd          in   3   0 NOP,1 LEFT,2 RIGHT,3 UP,4 DOWN,5 ZOOM_IN,6 ZOOM_OUT,7 HOME
//  cmd_ready    out  1   controller can accept a command
//  frame_done   in   1   fractal 'display' flag, level
//  frac_reset   out  1   reset to fractal engine (restarts a render)
//  startX       out  16  signed Q2.13 left edge
//  startY       out  16  signed Q2.13 top edge
//  stepX        out  16  Q2.13 x increment per pixel
//  stepY        out  16  Q2.13 y increment per pixel
//  busy         out  1   render in progress (LAUNCH or WAIT)
//  zoom_level   out  4   signed zoom count, +1 per effective ZOOM_IN
//  timeout      out  1   sticky; set when WAIT exceeds WAIT_MAX
// BEHAVIOUR
//  Reset: view regs = *_0 params, zoom_level=0, timeout=0, cmd_ready=0, busy=0,
//   frac_reset=1; state -> LAUNCH (initial render starts automatically).
//  FSM: IDLE, APPLY, LAUNCH, WAIT.
//  IDLE: cmd_ready=1. cmd_valid&&cmd_ready accepts cmd into register -> APPLY.
//  APPLY (1 cycle, cmd_ready=0): compute new view; if unchanged (NOP, zoom at
//   limit, zoom_level at +7/-8) -> IDLE, no render; else commit -> LAUNCH.
//  LAUNCH: frac_reset=1 for exactly RST_CYC cycles, busy=1 -> WAIT.
//  WAIT: frac_reset=0, busy=1; exit on first rising edge of frame_done (prev
//   sample registered; frame_done already high on entry is ignored) -> IDLE.
//   Counter reaching WAIT_MAX -> set timeout, -> IDLE.
//  View outputs are registers; they change only in APPLY, so they are stable
//   throughout LAUNCH/WAIT. Commands are never accepted while busy (no queue).
//  Arithmetic: 32-bit signed intermediates, result saturated to int16 range.
//   LEFT/RIGHT: startX -/+ (stepX<<PAN_SHIFT). UP/DOWN: startY -/+ (stepY<<PAN_SHIFT).
//   ZOOM_IN (both steps >= 2*STEP_MIN): step' = step>>1;
//    start' = start + step'*HALF_W (X) / step'*HALF_H (Y); zoom_level+1.
//   ZOOM_OUT (both steps <= STEP_MAX/2): start' = start - step*HALF_W/HALF_H;
//    step' = step<<1; zoom_level-1.
//   HOME: all view regs = *_0, zoom_level=0; renders even if already home.
//  Saturated pans still render if the value changed; a fully clamped pan is a no-op.
//  reset asserted in any state overrides: reset values above, new render issued.
// TESTING
//  1 Reset: 3 cycles reset -> frac_reset high 4 cycles after release, startX=E000,
//    stepX=25; pulse frame_done -> next cycle cmd_ready=1, busy=0.
//  2 RIGHT from home -> startX=E000+800=E320, startY unchanged, 4-cycle frac_reset,
//    busy until frame_done rise.
//  3 ZOOM_IN from home -> stepX=12, startX=E000+12*320=EF00, stepY=17,
//    startY=E000+17*240=EFF0, zoom_level=1; ZOOM_OUT -> stepX=24, startX=E000.
//  4 Zoom limits: STEP_MIN=16, ZOOM_IN at stepX=25 -> no frac_reset, IDLE after 2
//    cycles, outputs unchanged; NOP likewise.
//  5 cmd_valid held during WAIT -> not accepted (cmd_ready=0) until frame_done rise;
//    frame_done high entering WAIT is ignored.
//  6 WAIT_MAX=100, no frame_done -> timeout=1 at cycle 100, IDLE; HOME -> re-render,
//    timeout stays 1 until reset.

Source files
------------

// File: rtl/fractal_view_ctrl.sv
// View-window owner and render sequencer for the fractal engine: applies pan/zoom/home
// commands about the frame centre, then restarts the engine and waits for frame done.
module fractal_view_ctrl #(
  parameter logic signed [15:0] START_X0  = 16'shE000,
  parameter logic signed [15:0] START_Y0  = 16'shE000,
  parameter logic        [15:0] STEP_X0   = 16'd25,
  parameter logic        [15:0] STEP_Y0   = 16'd34,
  parameter int                 HALF_W    = 320,
  parameter int                 HALF_H    = 240,
  parameter int                 PAN_SHIFT = 5,
  parameter logic        [15:0] STEP_MIN  = 16'd1,
  parameter logic        [15:0] STEP_MAX  = 16'd2048,
  parameter int                 RST_CYC   = 4,
  parameter logic        [23:0] WAIT_MAX  = 24'hFFFFFF
) (
  input  logic               Clk_100M,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd,
  output logic               cmd_ready,
  input  logic               frame_done,
  output logic               frac_reset,
  output logic signed [15:0] startX,
  output logic signed [15:0] startY,
  output logic        [15:0] stepX,
  output logic        [15:0] stepY,
  output logic               busy,
  output logic signed [3:0]  zoom_level,
  output logic               timeout
);

  typedef enum logic [1:0] {IDLE, APPLY, LAUNCH, WAIT} state_t;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_LEFT, CMD_RIGHT, CMD_UP, CMD_DOWN, CMD_ZOOM_IN, CMD_ZOOM_OUT, CMD_HOME
  } cmd_t;

  localparam logic [7:0]  RST_LAST  = 8'(RST_CYC - 1);
  localparam logic [23:0] WAIT_LAST = WAIT_MAX - 24'd1;

  state_t state_q, state_d;
  cmd_t   cmd_q;
  logic [7:0]  rstCnt_q, rstCnt_d;
  logic [23:0] waitCnt_q, waitCnt_d;
  logic timeout_q, timeout_d;
  logic cmdReady_q, busy_q, fracReset_q;
  logic fdPrev_q;
  logic accept, commit;

  logic signed [15:0] startX_q, startY_q, startX_n, startY_n;
  logic        [15:0] stepX_q, stepY_q, stepX_n, stepY_n;
  logic signed [3:0]  zoom_q, zoom_n;
  logic forceRender, changed, zoomInOk, zoomOutOk;

  logic signed [31:0] startXw, startYw, stepXw, stepYw, halfXw, halfYw, panXw, panYw;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  assign startXw = 32'(startX_q);
  assign startYw = 32'(startY_q);
  assign stepXw  = $signed({16'd0, stepX_q});
  assign stepYw  = $signed({16'd0, stepY_q});
  assign halfXw  = $signed({17'd0, stepX_q[15:1]});
  assign halfYw  = $signed({17'd0, stepY_q[15:1]});
  assign panXw   = stepXw <<< PAN_SHIFT;
  assign panYw   = stepYw <<< PAN_SHIFT;

  // Zoom moves both axes together, so both steps must have room and the level must not wrap.
  assign zoomInOk  = ({1'b0, stepX_q} >= {STEP_MIN, 1'b0}) &&
                     ({1'b0, stepY_q} >= {STEP_MIN, 1'b0}) && (zoom_q != 4'sd7);
  assign zoomOutOk = (stepX_q <= (STEP_MAX >> 1)) && (stepY_q <= (STEP_MAX >> 1)) &&
                     (zoom_q != 4'sb1000);

  always_comb begin
    startX_n    = startX_q;
    startY_n    = startY_q;
    stepX_n     = stepX_q;
    stepY_n     = stepY_q;
    zoom_n      = zoom_q;
    forceRender = 1'b0;
    case (cmd_q)
      CMD_LEFT:  startX_n = sat16(startXw - panXw);
      CMD_RIGHT: startX_n = sat16(startXw + panXw);
      CMD_UP:    startY_n = sat16(startYw - panYw);
      CMD_DOWN:  startY_n = sat16(startYw + panYw);
      CMD_ZOOM_IN: begin
        if (zoomInOk) begin
          stepX_n  = stepX_q >> 1;
          stepY_n  = stepY_q >> 1;
          startX_n = sat16(startXw + halfXw * HALF_W);
          startY_n = sat16(startYw + halfYw * HALF_H);
          zoom_n   = zoom_q + 4'sd1;
        end
      end
      CMD_ZOOM_OUT: begin
        if (zoomOutOk) begin
          stepX_n  = stepX_q << 1;
          stepY_n  = stepY_q << 1;
          startX_n = sat16(startXw - stepXw * HALF_W);
          startY_n = sat16(startYw - stepYw * HALF_H);
          zoom_n   = zoom_q - 4'sd1;
        end
      end
      CMD_HOME: begin
        startX_n    = START_X0;
        startY_n    = START_Y0;
        stepX_n     = STEP_X0;
        stepY_n     = STEP_Y0;
        zoom_n      = 4'sd0;
        forceRender = 1'b1;
      end
      default: ;
    endcase
    changed = forceRender || (startX_n != startX_q) || (startY_n != startY_q) ||
              (stepX_n != stepX_q) || (stepY_n != stepY_q) || (zoom_n != zoom_q);
  end

  // A frame-done already high when WAIT is entered must not count, hence the edge detect.
  always_comb begin
    state_d   = state_q;
    rstCnt_d  = rstCnt_q;
    waitCnt_d = waitCnt_q;
    timeout_d = timeout_q;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmdReady_q) begin
          accept  = 1'b1;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (changed) begin
          commit   = 1'b1;
          rstCnt_d = 8'd0;
          state_d  = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        if (rstCnt_q == RST_LAST) begin
          rstCnt_d  = 8'd0;
          waitCnt_d = 24'd0;
          state_d   = WAIT;
        end else begin
          rstCnt_d = rstCnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (frame_done && !fdPrev_q) begin
          state_d = IDLE;
        end else if (waitCnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 24'd1;
        end
      end
      default: state_d = LAUNCH;
    endcase
  end

  always_ff @(posedge Clk_100M) begin
    fdPrev_q <= frame_done;
  end

  // Handshake outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      state_q     <= LAUNCH;
      cmd_q       <= CMD_NOP;
      rstCnt_q    <= 8'd0;
      waitCnt_q   <= 24'd0;
      timeout_q   <= 1'b0;
      cmdReady_q  <= 1'b0;
      busy_q      <= 1'b0;
      fracReset_q <= 1'b1;
      startX_q    <= START_X0;
      startY_q    <= START_Y0;
      stepX_q     <= STEP_X0;
      stepY_q     <= STEP_Y0;
      zoom_q      <= 4'sd0;
    end else begin
      state_q     <= state_d;
      rstCnt_q    <= rstCnt_d;
      waitCnt_q   <= waitCnt_d;
      timeout_q   <= timeout_d;
      cmdReady_q  <= (state_d == IDLE);
      busy_q      <= (state_d == LAUNCH) || (state_d == WAIT);
      fracReset_q <= (state_d == LAUNCH);
      if (accept) begin
        cmd_q <= cmd_t'(cmd);
      end
      if (commit) begin
        startX_q <= startX_n;
        startY_q <= startY_n;
        stepX_q  <= stepX_n;
        stepY_q  <= stepY_n;
        zoom_q   <= zoom_n;
      end
    end
  end

  assign cmd_ready  = cmdReady_q;
  assign busy       = busy_q;
  assign frac_reset = fracReset_q;
  assign timeout    = timeout_q;
  assign startX     = startX_q;
  assign startY     = startY_q;
  assign stepX      = stepX_q;
  assign stepY      = stepY_q;
  assign zoom_level = zoom_q;

endmodule

// File: tb/tb_fractal_view_ctrl.sv
// Scoreboard bench for fractal_view_ctrl: a reference view model queues the expected
// window for each command, compared once the controller is back in IDLE.
module tb_fractal_view_ctrl;

  localparam int RST_CYC  = 4;
  localparam int WAIT_MAX = 100;

  localparam logic [2:0] C_NOP = 3'd0, C_LEFT = 3'd1, C_RIGHT = 3'd2, C_UP = 3'd3,
                         C_DOWN = 3'd4, C_ZIN = 3'd5, C_ZOUT = 3'd6, C_HOME = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cmdValid, frameDone, cmdReady, fracReset, busy, timeout;
  logic [2:0]  cmdCode;
  logic [15:0] startX, startY, stepX, stepY;
  logic [3:0]  zoomLevel;

  logic        cmdValid2, frameDone2, cmdReady2, fracReset2, busy2, timeout2;
  logic [2:0]  cmdCode2;
  logic [15:0] startX2, startY2, stepX2, stepY2;
  logic [3:0]  zoomLevel2;

  fractal_view_ctrl #(.RST_CYC(RST_CYC), .WAIT_MAX(24'(WAIT_MAX))) dut (
    .Clk_100M(clk), .reset(reset), .cmd_valid(cmdValid), .cmd(cmdCode), .cmd_ready(cmdReady),
    .frame_done(frameDone), .frac_reset(fracReset), .startX(startX), .startY(startY),
    .stepX(stepX), .stepY(stepY), .busy(busy), .zoom_level(zoomLevel), .timeout(timeout)
  );

  fractal_view_ctrl #(.STEP_MIN(16'd16), .RST_CYC(RST_CYC), .WAIT_MAX(24'(WAIT_MAX))) dutMin (
    .Clk_100M(clk), .reset(reset), .cmd_valid(cmdValid2), .cmd(cmdCode2), .cmd_ready(cmdReady2),
    .frame_done(frameDone2), .frac_reset(fracReset2), .startX(startX2), .startY(startY2),
    .stepX(stepX2), .stepY(stepY2), .busy(busy2), .zoom_level(zoomLevel2), .timeout(timeout2)
  );

  typedef struct {
    logic [15:0] sx, sy, stx, sty;
    logic [3:0]  zl;
    logic        render;
  } expView_t;

  expView_t expQ[$];
  int assertCount = 0;
  int failCount   = 0;
  int mSx, mSy, mStx, mSty, mZl;
  int lastWaitCyc;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic modelReset();
    mSx = -8192; mSy = -8192; mStx = 25; mSty = 34; mZl = 0;
  endtask

  // Reference view update; pushes what the DUT should show after this command.
  task automatic modelApply(input logic [2:0] c);
    int nsx, nsy, nstx, nsty, nzl;
    bit forceR;
    expView_t e;
    nsx = mSx; nsy = mSy; nstx = mStx; nsty = mSty; nzl = mZl; forceR = 0;
    case (c)
      C_LEFT:  nsx = sat16(mSx - mStx * 32);
      C_RIGHT: nsx = sat16(mSx + mStx * 32);
      C_UP:    nsy = sat16(mSy - mSty * 32);
      C_DOWN:  nsy = sat16(mSy + mSty * 32);
      C_ZIN: if (mStx >= 2 && mSty >= 2 && mZl < 7) begin
        nstx = mStx / 2; nsty = mSty / 2;
        nsx = sat16(mSx + nstx * 320); nsy = sat16(mSy + nsty * 240); nzl = mZl + 1;
      end
      C_ZOUT: if (mStx <= 1024 && mSty <= 1024 && mZl > -8) begin
        nsx = sat16(mSx - mStx * 320); nsy = sat16(mSy - mSty * 240);
        nstx = mStx * 2; nsty = mSty * 2; nzl = mZl - 1;
      end
      C_HOME: begin
        nsx = -8192; nsy = -8192; nstx = 25; nsty = 34; nzl = 0; forceR = 1;
      end
      default: ;
    endcase
    e.render = forceR || nsx != mSx || nsy != mSy || nstx != mStx || nsty != mSty || nzl != mZl;
    mSx = nsx; mSy = nsy; mStx = nstx; mSty = nsty; mZl = nzl;
    e.sx = 16'(mSx); e.sy = 16'(mSy); e.stx = 16'(mStx); e.sty = 16'(mSty); e.zl = 4'(mZl);
    expQ.push_back(e);
  endtask

  task automatic waitReady(input int bound);
    int n = 0;
    while (!cmdReady && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!cmdReady) checkOutput("wait_ready_bound", 32'(cmdReady), 32'd1);
  endtask

  task automatic compareView();
    expView_t e;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkOutput("startX", 32'(startX), 32'(e.sx));
    checkOutput("startY", 32'(startY), 32'(e.sy));
    checkOutput("stepX", 32'(stepX), 32'(e.stx));
    checkOutput("stepY", 32'(stepY), 32'(e.sty));
    checkOutput("zoom_level", 32'(zoomLevel), 32'(e.zl));
  endtask

  // Called at the negedge inside APPLY; follows LAUNCH/WAIT back to IDLE.
  task automatic finishRender(input bit pulseDone);
    int rstSeen = 0;
    int waitCyc = 0;
    bit expRender;
    @(negedge clk);
    while (fracReset && rstSeen < 20) begin
      checkOutput("launch_busy", 32'(busy), 32'd1);
      rstSeen++;
      @(negedge clk);
    end
    if (rstSeen > 0) begin
      if (pulseDone) begin
        checkOutput("wait_busy", 32'(busy), 32'd1);
        frameDone = 1'b1;
        @(negedge clk);
        frameDone = 1'b0;
      end else begin
        while (busy && waitCyc < 300) begin
          waitCyc++;
          @(negedge clk);
        end
      end
    end
    lastWaitCyc = waitCyc;
    checkOutput("done_ready", 32'(cmdReady), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd0);
    expRender = (expQ.size() > 0) ? expQ[0].render : 1'b0;
    checkOutput("rst_cycles", 32'(rstSeen), expRender ? 32'(RST_CYC) : 32'd0);
    compareView();
  endtask

  task automatic applyStimulus(input logic [2:0] c, input bit pulseDone);
    waitReady(400);
    modelApply(c);
    cmdValid = 1'b1;
    cmdCode  = c;
    @(negedge clk);
    cmdValid = 1'b0;
    checkOutput("apply_ready", 32'(cmdReady), 32'd0);
    finishRender(pulseDone);
  endtask

  task automatic resetDut();
    int rstSeen = 0;
    reset = 1'b1; cmdValid = 1'b0; frameDone = 1'b0; cmdValid2 = 1'b0; frameDone2 = 1'b0;
    cmdCode = C_NOP; cmdCode2 = C_NOP;
    repeat (3) @(negedge clk);
    checkOutput("rst_frac_reset", 32'(fracReset), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(cmdReady), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_startX", 32'(startX), 32'h0000E000);
    checkOutput("rst_stepX", 32'(stepX), 32'd25);
    checkOutput("rst_zoom", 32'(zoomLevel), 32'd0);
    reset = 1'b0;
    modelReset();
    expQ.delete();
    while (fracReset && rstSeen < 20) begin
      rstSeen++;
      @(negedge clk);
    end
    checkOutput("rst_launch_cycles", 32'(rstSeen), 32'(RST_CYC));
    checkOutput("rst_wait_busy", 32'(busy), 32'd1);
    checkOutput("rst_wait_ready", 32'(cmdReady), 32'd0);
    frameDone = 1'b1; frameDone2 = 1'b1;
    @(negedge clk);
    frameDone = 1'b0; frameDone2 = 1'b0;
    checkOutput("rst_done_ready", 32'(cmdReady), 32'd1);
    checkOutput("rst_done_busy", 32'(busy), 32'd0);
    checkOutput("rst_done_ready_min", 32'(cmdReady2), 32'd1);
  endtask

  // The high-floor instance must swallow ZOOM_IN at home and NOP without rendering.
  task automatic checkMinInstance(input logic [2:0] c);
    checkOutput("min_ready_pre", 32'(cmdReady2), 32'd1);
    cmdValid2 = 1'b1; cmdCode2 = c;
    @(negedge clk);
    cmdValid2 = 1'b0;
    checkOutput("min_apply_ready", 32'(cmdReady2), 32'd0);
    checkOutput("min_apply_frac", 32'(fracReset2), 32'd0);
    @(negedge clk);
    checkOutput("min_idle_ready", 32'(cmdReady2), 32'd1);
    checkOutput("min_idle_frac", 32'(fracReset2), 32'd0);
    checkOutput("min_idle_busy", 32'(busy2), 32'd0);
    checkOutput("min_stepX", 32'(stepX2), 32'd25);
    checkOutput("min_startX", 32'(startX2), 32'h0000E000);
    checkOutput("min_zoom", 32'(zoomLevel2), 32'd0);
  endtask

  // cmd_valid held through a render, with frame_done already high on entering WAIT.
  task automatic heldCommandDuringWait();
    int rstSeen = 0;
    waitReady(400);
    modelApply(C_LEFT);
    cmdValid = 1'b1; cmdCode = C_LEFT;
    @(negedge clk);
    cmdCode = C_RIGHT;
    frameDone = 1'b1;
    @(negedge clk);
    while (fracReset && rstSeen < 20) begin
      rstSeen++;
      @(negedge clk);
    end
    checkOutput("held_rst_cycles", 32'(rstSeen), 32'(RST_CYC));
    repeat (5) begin
      checkOutput("held_ready_low", 32'(cmdReady), 32'd0);
      checkOutput("held_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    frameDone = 1'b0;
    @(negedge clk);
    checkOutput("held_busy_after_drop", 32'(busy), 32'd1);
    frameDone = 1'b1;
    @(negedge clk);
    frameDone = 1'b0;
    checkOutput("held_ready_after_rise", 32'(cmdReady), 32'd1);
    compareView();
    modelApply(C_RIGHT);
    @(negedge clk);
    cmdValid = 1'b0;
    checkOutput("held_apply_ready", 32'(cmdReady), 32'd0);
    finishRender(1'b1);
  endtask

  initial begin
    resetDut();
    checkMinInstance(C_ZIN);
    checkMinInstance(C_NOP);

    applyStimulus(C_RIGHT, 1'b1);
    checkOutput("right_startX", 32'(startX), 32'h0000E320);
    applyStimulus(C_HOME, 1'b1);
    applyStimulus(C_ZIN, 1'b1);
    checkOutput("zin_startX", 32'(startX), 32'h0000EF00);
    checkOutput("zin_startY", 32'(startY), 32'h0000EFF0);
    applyStimulus(C_ZOUT, 1'b1);
    checkOutput("zout_stepX", 32'(stepX), 32'd24);
    applyStimulus(C_NOP, 1'b1);
    applyStimulus(C_LEFT, 1'b1);
    applyStimulus(C_UP, 1'b1);
    applyStimulus(C_DOWN, 1'b1);

    applyStimulus(C_HOME, 1'b1);
    repeat (5) applyStimulus(C_ZIN, 1'b1);
    applyStimulus(C_HOME, 1'b1);
    repeat (6) applyStimulus(C_ZOUT, 1'b1);
    applyStimulus(C_LEFT, 1'b1);
    applyStimulus(C_RIGHT, 1'b1);
    applyStimulus(C_LEFT, 1'b1);
    applyStimulus(C_LEFT, 1'b1);
    repeat (3) applyStimulus(C_UP, 1'b1);
    applyStimulus(C_HOME, 1'b1);

    heldCommandDuringWait();

    applyStimulus(C_DOWN, 1'b0);
    checkOutput("timeout_wait_cycles", 32'(lastWaitCyc), 32'(WAIT_MAX));
    checkOutput("timeout_set", 32'(timeout), 32'd1);
    applyStimulus(C_HOME, 1'b1);
    checkOutput("timeout_sticky", 32'(timeout), 32'd1);
    applyStimulus(C_HOME, 1'b1);

    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_clears_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_again_frac", 32'(fracReset), 32'd1);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
